imem_fetch_buf: RTL and testbench
=================================

# imem_fetch_buf

Parametrised instruction-fetch memory for the MIPS32 core. It replaces the asynchronous, word-indexed instruction ROM with the following:
- a synchronous-read word array addressed by byte PC;
- valid/ready request and response handshakes with a small response FIFO;
- alignment and range fault detection;
- a pipeline flush for branches and jumps;
- a write port for loading the program.

It sits between the IF-stage PC logic and the IF/ID pipeline register.

## Interface
- DATA_W, 32, instruction word width in bits
- ADDR_W, 32, byte-address width
- DEPTH, 1024, number of words (power of two)
- FIFO_DEPTH, 4, response FIFO entries (power of two, ≥2)

- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  fetch request present
- req_ready  out  1  request can be accepted this cycle
- req_addr  in  ADDR_W  byte address of instruction
- rsp_valid  out  1  FIFO head valid
- rsp_ready  in  1  consumer takes head this cycle
- rsp_data  out  DATA_W  instruction word (0 on fault)
- rsp_addr  out  ADDR_W  byte address the response belongs to
- rsp_fault  out  1  misaligned or out-of-range request
- flush  in  1  discard all in-flight and buffered responses
- prog_we  in  1  program write enable
- prog_addr  in  ADDR_W  program write byte address (must be word aligned)
- prog_data  in  DATA_W  program write data

## Operation
- Accept: a request is accepted when req_valid && req_ready. Word index = req_addr[log2(DEPTH)+1:2].
- Fault: rsp_fault=1 and rsp_data=0 when either of these holds:
  - req_addr[1:0] != 0;
  - req_addr >> 2 ≥ DEPTH (any upper bit above the index set).
- Read: memory is read on the accept edge into a one-stage in-flight register (data, addr, fault, valid). On the next edge the in-flight entry is pushed into the FIFO.
- Occupancy: req_ready = !flush && (fifo_count + inflight_valid) < FIFO_DEPTH. req_ready has no combinational path from rsp_ready or req_valid.
- Output: rsp_* present the FIFO head. A pop occurs on rsp_valid && rsp_ready. Push and pop may occur in the same cycle; count is unchanged.
- Flush: on an edge with flush=1, the in-flight valid, FIFO count and pointers clear. A request presented in that cycle is not accepted, since req_ready=0.
- Program write: on an edge with prog_we=1, mem[prog_addr index] ← prog_data.
  - Misaligned or out-of-range prog_addr is ignored.
  - A same-cycle read of the same word returns the old data (read-before-write).
- Memory contents are not reset.
- State: IDLE (fifo empty, no in-flight) and BUSY (otherwise), derived from counters. No other FSM.

## Timing
- Reset values:
  - req_ready=0 while rst=1, and 1 on the first cycle after release;
  - rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_fault=0;
  - fifo_count=0, inflight_valid=0, pointers=0.
- rst asserted mid-operation clears all buffered and in-flight responses immediately (asynchronous). Outputs take their reset values on assertion.
- Latency: request accepted at edge N gives rsp_valid=1 after edge N+1 (one cycle), when the FIFO was empty.
- Throughput: one instruction per cycle sustained while rsp_ready=1.
- Backpressure: with rsp_ready=0, at most FIFO_DEPTH requests are outstanding, then req_ready=0. Head outputs hold stable while rsp_valid && !rsp_ready.
- Full with simultaneous pop: req_ready is computed from registered state only. A pop frees space for the following cycle.
- Pointer wrap: pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
- Flush and pop in the same cycle: flush wins, and the FIFO is empty after the edge.
- Flush with an in-flight entry: that entry is dropped and is never pushed.

## Test plan
- Reset then load: write mem[0..3]=0x20010005, 0x20020003, 0x00221820, 0xAC030000 via prog_we. Fetch addresses 0,4,8,12 back-to-back with rsp_ready=1 → rsp_valid from cycle 2, with one word per cycle in order and matching rsp_addr.
- Backpressure: rsp_ready=0, issue 6 requests → exactly 4 accepted, req_ready=0 afterwards. Then release rsp_ready → 4 ordered responses, and req_ready returns 1 the cycle after the first pop.
- Faults: fetch 0x2 → rsp_fault=1, rsp_data=0. Fetch 0x1000 with DEPTH=1024 → rsp_fault=1. Fetch 0x4 → fault=0 and correct data.
- Flush: 3 responses buffered plus 1 in flight, assert flush for one cycle → rsp_valid=0 next cycle. A new fetch of 0x8 returns only mem[2].
- Read-before-write: same cycle, fetch 0x10 and prog_write 0x10=0xDEADBEEF → response carries the old value. A refetch returns 0xDEADBEEF.
- Async reset mid-stream: assert rst between edges with 2 entries buffered → rsp_valid=0 immediately, and no stale responses after release.

Source files
------------

// File: rtl/imem_fetch_buf_if.sv
// Fetch-side bus of the instruction memory: request and response
// handshakes, pipeline flush and the program-load write port.
interface imem_fetch_buf_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rsp_fault;

    logic              flush;

    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;

    // IF-stage PC logic / program loader side
    modport master (
        output req_valid, req_addr, rsp_ready, flush,
               prog_we, prog_addr, prog_data,
        input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_fault
    );

    // Instruction memory side
    modport slave (
        input  req_valid, req_addr, rsp_ready, flush,
               prog_we, prog_addr, prog_data,
        output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_fault
    );
endinterface

// File: rtl/imem_fetch_buf.sv
// Instruction-fetch memory: synchronous-read word array addressed by byte
// PC, one in-flight read stage feeding a small response FIFO, alignment and
// range fault detection, pipeline flush and a program-load write port.
module imem_fetch_buf #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    imem_fetch_buf_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;
    localparam logic [OCC_W-1:0] OCC_LIMIT = OCC_W'(FIFO_DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    // Word storage (never reset)
    logic [DATA_W-1:0] r_mem [DEPTH];

    // In-flight read stage
    logic [DATA_W-1:0] r_if_word;
    logic [ADDR_W-1:0] r_if_addr;
    logic              r_if_fault;
    logic              r_if_valid;

    // Response FIFO
    logic [DATA_W-1:0] r_fifo_data  [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_fifo_addr  [FIFO_DEPTH];
    logic              r_fifo_fault [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic [IDX_W-1:0]  w_req_idx;
    logic              w_req_fault;
    logic [IDX_W-1:0]  w_prog_idx;
    logic              w_prog_ok;
    logic [OCC_W-1:0]  w_occ;
    logic              w_req_ready;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_rsp_valid;
    state_t            w_state;

    // Address decode, occupancy, handshake qualification and derived state
    always_comb begin
        w_req_idx   = bus.req_addr[IDX_W+1:2];
        w_req_fault = (bus.req_addr[1:0] != 2'b00) ||
                      (bus.req_addr[ADDR_W-1:IDX_W+2] != '0);
        w_prog_idx  = bus.prog_addr[IDX_W+1:2];
        w_prog_ok   = bus.prog_we &&
                      (bus.prog_addr[1:0] == 2'b00) &&
                      (bus.prog_addr[ADDR_W-1:IDX_W+2] == '0);
        // Only registered state and flush feed req_ready; the in-flight
        // slot is counted so a full FIFO can never be overrun.
        w_occ       = OCC_W'(r_count) + OCC_W'(r_if_valid);
        w_req_ready = !rst && !bus.flush && (w_occ < OCC_LIMIT);
        w_accept    = bus.req_valid && w_req_ready;
        w_state     = ((r_count == '0) && !r_if_valid) ? ST_IDLE : ST_BUSY;
        w_rsp_valid = (w_state == ST_BUSY) && (r_count != '0);
        w_push      = r_if_valid && !bus.flush;
        w_pop       = w_rsp_valid && bus.rsp_ready && !bus.flush;
    end

    // Response outputs present the FIFO head, zeroed while empty
    always_comb begin
        bus.req_ready = w_req_ready;
        bus.rsp_valid = w_rsp_valid;
        bus.rsp_data  = '0;
        bus.rsp_addr  = '0;
        bus.rsp_fault = 1'b0;
        if (w_rsp_valid) begin
            bus.rsp_data  = r_fifo_data[r_rd_ptr];
            bus.rsp_addr  = r_fifo_addr[r_rd_ptr];
            bus.rsp_fault = r_fifo_fault[r_rd_ptr];
        end
    end

    // Synchronous read on accept and program write; the non-blocking read
    // sees the pre-write contents, giving read-before-write on a collision
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_if_word <= r_mem[w_req_idx];
        end
        if (w_prog_ok) begin
            r_mem[w_prog_idx] <= bus.prog_data;
        end
    end

    // FIFO payload write; faulted entries carry a zero instruction word
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr]  <= r_if_fault ? '0 : r_if_word;
            r_fifo_addr[r_wr_ptr]  <= r_if_addr;
            r_fifo_fault[r_wr_ptr] <= r_if_fault;
        end
    end

    // In-flight stage, pointers and count; flush overrides push and pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_valid <= 1'b0;
            r_if_addr  <= '0;
            r_if_fault <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else if (bus.flush) begin
            r_if_valid <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_if_valid <= w_accept;
            if (w_accept) begin
                r_if_addr  <= bus.req_addr;
                r_if_fault <= w_req_fault;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_fetch_buf.sv
// Self-checking bench for imem_fetch_buf: directed vectors and corner-case
// sequences, then randomized traffic against a queue-based reference model.
module tb_imem_fetch_buf;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MD = 1024;
    localparam int FD = 4;

    logic clk;
    logic rst;

    imem_fetch_buf_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    imem_fetch_buf #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(MD), .FIFO_DEPTH(FD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the first 16 memory words (only these are ever fetched in range)
    logic [31:0] pm [16];

    typedef struct {
        logic [31:0] addr;
        logic        fault;
        logic [31:0] data;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        fault;
        int          acc_it;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic addr_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(MD));
    endfunction

    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.rsp_ready = 1'b0;
        bus.flush     = 1'b0;
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
    endtask

    task automatic prog_write(input int idx, input logic [31:0] d);
        bus.prog_we   = 1'b1;
        bus.prog_addr = 32'(idx * 4);
        bus.prog_data = d;
        @(posedge clk); #1;
        bus.prog_we   = 1'b0;
        pm[idx]       = d;
    endtask

    // Waits (bounded) for a response with rsp_ready=1; lat counts negedges
    // after the accept edge until rsp_valid is seen.
    task automatic wait_rsp(output logic got, output logic [31:0] d,
                            output logic [31:0] ra, output logic f, output int lat);
        got = 1'b0; d = '0; ra = '0; f = 1'b0; lat = -1;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                got = 1'b1; d = bus.rsp_data; ra = bus.rsp_addr;
                f = bus.rsp_fault; lat = k;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic fetch_one(input logic [31:0] a, output logic got, output logic [31:0] d,
                             output logic [31:0] ra, output logic f, output int lat);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        wait_rsp(got, d, ra, f, lat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[10];
        logic        got;
        logic [31:0] d;
        logic [31:0] ra;
        logic        f;
        int          lat;
        int          acc;

        idle_inputs();
        rst = 1'b1;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data",  bus.rsp_data,  0);
        chk("rst_rsp_addr",  bus.rsp_addr,  0);
        chk("rst_rsp_fault", bus.rsp_fault, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", bus.req_ready, 1);
        @(posedge clk); #1;

        // ---------------- program load ----------------
        prog_write(0, 32'h2001_0005);
        prog_write(1, 32'h2002_0003);
        prog_write(2, 32'h0022_1820);
        prog_write(3, 32'hAC03_0000);
        for (int i = 4; i < 16; i++) prog_write(i, 32'h1000_0000 + 32'(i * 32'h11));

        // ---------------- back-to-back fetch 0,4,8,12 ----------------
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (k + 1 < 4) bus.req_addr = 32'((k + 1) * 4);
            else           bus.req_valid = 1'b0;
            @(negedge clk);
            if (k == 0) begin
                chk("b2b_first_inflight", bus.rsp_valid, 0);
            end else begin
                chk("b2b_valid", bus.rsp_valid, 1);
                chk("b2b_addr",  bus.rsp_addr, 32'((k - 1) * 4));
                chk("b2b_data",  bus.rsp_data, pm[k - 1]);
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_drained", bus.rsp_valid, 0);
        @(posedge clk); #1;

        // ---------------- table-driven single fetches ----------------
        tbl[0] = '{32'h0000_0000, 1'b0, 32'h2001_0005};
        tbl[1] = '{32'h0000_0004, 1'b0, 32'h2002_0003};
        tbl[2] = '{32'h0000_0008, 1'b0, 32'h0022_1820};
        tbl[3] = '{32'h0000_000C, 1'b0, 32'hAC03_0000};
        tbl[4] = '{32'h0000_0002, 1'b1, 32'h0};
        tbl[5] = '{32'h0000_1000, 1'b1, 32'h0};
        tbl[6] = '{32'h0000_0004, 1'b0, 32'h2002_0003};
        tbl[7] = '{32'h0000_0003, 1'b1, 32'h0};
        tbl[8] = '{32'h8000_0004, 1'b1, 32'h0};
        tbl[9] = '{32'h0000_003C, 1'b0, 32'h1000_00FF};
        for (int i = 0; i < 10; i++) begin
            fetch_one(tbl[i].addr, got, d, ra, f, lat);
            chk("vec_got",   got, 1);
            chk("vec_lat",   lat, 1);
            chk("vec_addr",  ra, tbl[i].addr);
            chk("vec_fault", f, tbl[i].fault);
            chk("vec_data",  d, tbl[i].data);
        end

        // ---------------- backpressure ----------------
        bus.rsp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = 32'(i * 4);
            @(negedge clk);
            if (bus.req_ready) acc++;
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        chk("bp_accepted", acc, 4);
        @(negedge clk);
        chk("bp_ready_full", bus.req_ready, 0);
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_ready_full_during_pop", bus.req_ready, 0);
        for (int k = 0; k < 4; k++) begin
            chk("bp_valid", bus.rsp_valid, 1);
            chk("bp_addr",  bus.rsp_addr, 32'(k * 4));
            chk("bp_data",  bus.rsp_data, pm[k]);
            @(posedge clk); #1;
            if (k == 0) chk("bp_ready_after_pop", bus.req_ready, 1);
            @(negedge clk);
        end
        chk("bp_drained", bus.rsp_valid, 0);
        @(posedge clk); #1;

        // ---------------- flush with 3 buffered + 1 in flight ----------------
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = 32'(i * 4);
            @(posedge clk); #1;
        end
        bus.req_addr = 32'h10;
        bus.flush    = 1'b1;
        #1;
        chk("flush_req_ready", bus.req_ready, 0);
        @(posedge clk); #1;
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("flush_empty", bus.rsp_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("flush_inflight_dropped", bus.rsp_valid, 0);
        @(posedge clk); #1;
        fetch_one(32'h8, got, d, ra, f, lat);
        chk("flush_refetch_got",  got, 1);
        chk("flush_refetch_addr", ra, 32'h8);
        chk("flush_refetch_data", d, pm[2]);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("flush_no_stale", bus.rsp_valid, 0);
            @(posedge clk); #1;
        end

        // ---------------- read-before-write ----------------
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h10;
        bus.prog_we   = 1'b1;
        bus.prog_addr = 32'h10;
        bus.prog_data = 32'hDEAD_BEEF;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.prog_we   = 1'b0;
        wait_rsp(got, d, ra, f, lat);
        chk("rbw_got",      got, 1);
        chk("rbw_old_data", d, pm[4]);
        pm[4] = 32'hDEAD_BEEF;
        fetch_one(32'h10, got, d, ra, f, lat);
        chk("rbw_new_data", d, 32'hDEAD_BEEF);

        // ---------------- async reset mid-stream ----------------
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = 32'(i * 4);
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("arst_pre_valid", bus.rsp_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", bus.rsp_valid, 0);
        chk("arst_ready", bus.req_ready, 0);
        chk("arst_data",  bus.rsp_data,  0);
        chk("arst_addr",  bus.rsp_addr,  0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("arst_no_stale", bus.rsp_valid, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("arst_ready_after", bus.req_ready, 1);
        @(posedge clk); #1;

        // ---------------- randomized traffic vs queue model ----------------
        q.delete();
        for (int t = 0; t < 1500; t++) begin
            int          sel;
            int          idx;
            logic        exp_ready;
            logic        exp_valid;
            logic [31:0] a;
            exp_t        e;

            idx = $urandom_range(0, 15);
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = 32'(idx * 4);
            else if (sel == 7) a = 32'(idx * 4 + $urandom_range(1, 3));
            else               a = (32'($urandom_range(1, 255)) << 12) | 32'(idx * 4);
            bus.req_valid = ($urandom_range(0, 9) < 7);
            bus.req_addr  = a;
            bus.rsp_ready = ($urandom_range(0, 9) < 7);
            bus.flush     = ($urandom_range(0, 19) == 0);

            idx = $urandom_range(0, 15);
            sel = $urandom_range(0, 9);
            if (sel < 6)       a = 32'(idx * 4);
            else if (sel < 8)  a = 32'(idx * 4 + $urandom_range(1, 3));
            else               a = (32'($urandom_range(1, 255)) << 12) | 32'(idx * 4);
            bus.prog_we   = ($urandom_range(0, 7) == 0);
            bus.prog_addr = a;
            bus.prog_data = $urandom;

            @(negedge clk);
            exp_ready = !bus.flush && (q.size() < FD);
            exp_valid = (q.size() > 0) && (q[0].acc_it <= t - 2);
            chk("rnd_req_ready", bus.req_ready, exp_ready);
            chk("rnd_rsp_valid", bus.rsp_valid, exp_valid);
            if (exp_valid) begin
                chk("rnd_rsp_addr",  bus.rsp_addr,  q[0].addr);
                chk("rnd_rsp_fault", bus.rsp_fault, q[0].fault);
                chk("rnd_rsp_data",  bus.rsp_data,  q[0].data);
            end

            if (bus.flush) begin
                q.delete();
            end else begin
                if (exp_valid && bus.rsp_ready) void'(q.pop_front());
                if (bus.req_valid && exp_ready) begin
                    e.addr   = bus.req_addr;
                    e.fault  = addr_fault(bus.req_addr);
                    e.data   = e.fault ? 32'h0 : pm[bus.req_addr[5:2]];
                    e.acc_it = t;
                    q.push_back(e);
                end
            end
            if (bus.prog_we && !addr_fault(bus.prog_addr)) pm[bus.prog_addr[5:2]] = bus.prog_data;

            @(posedge clk); #1;
        end

        idle_inputs();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
